// File: rtl/seq_scan_ctrl.sv
// Frame-level controller: accepts a word, shifts it MSB-first through a serial pattern
// detector, counts matches and returns the count. Define SEQ_OVERLAP_EN for overlapping detection.
module seq_scan_ctrl #(
  parameter int unsigned     WORD_W  = 16,
  parameter int unsigned     PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int unsigned     CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              match,
  output logic              busy
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam int unsigned BitW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
  localparam logic [BitW-1:0]  LastBit  = BitW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  shreg_q;
  logic [PAT_W-1:0]   win_q;
  logic [FillW-1:0]   fill_q;
  logic [BitW-1:0]    bitcnt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               match_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               in_ready_q;

  logic               shift_bit;
  logic [PAT_W-1:0]   win_nxt;
  logic [FillW-1:0]   fill_nxt;
  logic [FillW-1:0]   fill_after_hit;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit;
  logic               last_bit;

  always_comb begin
    shift_bit = shreg_q[WORD_W-1];
    win_nxt   = {win_q[PAT_W-2:0], shift_bit};
    fill_nxt  = (fill_q == FillFull) ? fill_q : fill_q + FillW'(1);
    hit       = (fill_nxt == FillFull) && (win_nxt == PATTERN);
    last_bit  = (bitcnt_q == LastBit);
    cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef SEQ_OVERLAP_EN
    fill_after_hit = fill_nxt;
`else
    // Non-overlapping: the next match must be built entirely from fresh bits.
    fill_after_hit = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      win_q       <= '0;
      fill_q      <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      match_q     <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      match_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            shreg_q    <= in_data;
            win_q      <= '0;
            fill_q     <= '0;
            bitcnt_q   <= '0;
            cnt_q      <= '0;
            state_q    <= StShift;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StShift: begin
          if (abort) begin
            // Abort wins over the last bit; the partial count is dropped.
            state_q    <= StIdle;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            shreg_q  <= shreg_q << 1;
            win_q    <= win_nxt;
            bitcnt_q <= bitcnt_q + BitW'(1);
            if (hit) begin
              match_q <= 1'b1;
              cnt_q   <= cnt_inc;
              fill_q  <= fill_after_hit;
            end else begin
              fill_q <= fill_nxt;
            end
            if (last_bit) begin
              state_q     <= StDone;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_count = cnt_q;
  assign match     = match_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Randomized self-checking bench for seq_scan_ctrl against a substring-search reference model.
module tb_seq_scan_ctrl;

  localparam int unsigned     WORD_W  = 16;
  localparam int unsigned     PAT_W   = 4;
  localparam logic [PAT_W-1:0] PATTERN = 4'b1011;
  localparam int unsigned     CNT_W   = 5;
  localparam int              CntMax  = (1 << CNT_W) - 1;
`ifdef SEQ_OVERLAP_EN
  localparam bit Overlap = 1'b1;
`else
  localparam bit Overlap = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              match;
  logic              busy;

  int n_total;
  int n_bad;
  int exp_cnt;
  bit exp_hit [WORD_W];

  seq_scan_ctrl #(
    .WORD_W  (WORD_W),
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .match     (match),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Pattern search over the word as a bit string (index 0 = first bit shifted out).
  task automatic model(input logic [WORD_W-1:0] w);
    int last_end;
    int start;
    logic [PAT_W-1:0] seg;
    last_end = -1;
    exp_cnt  = 0;
    for (int j = 0; j < WORD_W; j++) exp_hit[j] = 1'b0;
    for (int j = PAT_W - 1; j < WORD_W; j++) begin
      start = j - PAT_W + 1;
      for (int k = 0; k < PAT_W; k++) seg[PAT_W-1-k] = w[WORD_W-1-(start+k)];
      if (seg == PATTERN && (Overlap || start > last_end)) begin
        exp_hit[j] = 1'b1;
        if (exp_cnt < CntMax) exp_cnt++;
        last_end = j;
      end
    end
  endtask

  // Enter at #1 after an edge with the DUT idle; abort_at = shift edge that samples abort.
  task automatic run_word(input logic [WORD_W-1:0] w, input int hold, input int abort_at);
    model(w);
    in_data   = w;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = WORD_W'($urandom);
    check("accept_in_ready", 32'(in_ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_cnt_clr", 32'(out_count), 32'd0);
    for (int k = 1; k <= WORD_W; k++) begin
      abort = (k == abort_at);
      @(posedge clk); #1;
      abort   = 1'b0;
      in_data = WORD_W'($urandom);
      if (k == abort_at) begin
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (2) begin
          @(posedge clk); #1;
          check("abort_no_valid", 32'(out_valid), 32'd0);
          check("abort_match", 32'(match), 32'd0);
        end
        return;
      end
      check("match", 32'(match), 32'(exp_hit[k-1]));
      check("out_valid_edge", 32'(out_valid), 32'(k == WORD_W));
      check("busy", 32'(busy), 32'(k != WORD_W));
    end
    check("count", 32'(out_count), 32'(exp_cnt));
    check("done_in_ready", 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'(($urandom % 2));
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_count", 32'(out_count), 32'(exp_cnt));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_out_valid", 32'(out_valid), 32'd0);
    check("ret_in_ready", 32'(in_ready), 32'd1);
    check("ret_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_word(16'hB000, 0, 0);
    run_word(16'hB6C0, 0, 0);
    run_word(16'hFFFF, 0, 0);
    run_word(16'hB000, 5, 0);
    run_word(16'hB6C0, 0, 10);
    run_word(16'hB000, 0, 0);
    run_word(16'hBBBB, 1, WORD_W);

    // Asynchronous reset in the middle of a scan.
    in_data  = 16'hBBBB;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_match", 32'(match), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_word(16'hBBBB, 0, 0);

    for (int r = 0; r < 40; r++) begin
      int ab;
      ab = (($urandom % 5) == 0) ? int'($urandom_range(1, WORD_W)) : 0;
      run_word(WORD_W'($urandom), int'($urandom_range(0, 4)), ab);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
